rob_complete_unit: RTL and testbench

ROB_COMPLETE_UNIT -- requirements
Module: rob_complete_unit

---
 rtl/sys_defs.sv | 34 +++
 rtl/rob_complete_unit_if.sv | 26 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/rob_complete_unit.sv | 96 +++++++++
 tb/tb_rob_complete_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/sys_defs.sv
// Shared system definitions: ROB/PR sizing, completion packet and
// completion holding-register entry types, plus ROB age comparison.
`ifndef NUM_ROB
`define NUM_ROB 32
`endif
`ifndef NUM_PR
`define NUM_PR 64
`endif

package sys_defs;

    localparam int unsigned ROB_IDX_W = $clog2(`NUM_ROB);
    localparam int unsigned PR_IDX_W  = $clog2(`NUM_PR);

    typedef struct packed {
        logic                 complete_en;
        logic [ROB_IDX_W-1:0] complete_ROB_idx;
    } ROB_PACKET_COMPLETE_IN;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] ROB_idx;
        logic [PR_IDX_W-1:0]  T_idx;
    } COMPLETE_UNIT_ENTRY_t;

    // Entry idx sits strictly between branch br and tail, walking the ring forward.
    function automatic logic is_younger(input logic [ROB_IDX_W-1:0] idx,
                                        input logic [ROB_IDX_W-1:0] br,
                                        input logic [ROB_IDX_W-1:0] tail);
        if (br < tail) return (idx > br) && (idx < tail);
        return (idx > br) || (idx < tail);
    endfunction

endpackage

// File: rtl/rob_complete_unit_if.sv
// FU result / rollback / completion bundle between the FUs, ROB and complete unit.
interface rob_complete_unit_if
    import sys_defs::*;
#(
    parameter int unsigned NUM_FU = 4
);
    logic [NUM_FU-1:0]                fu_valid;
    logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_ROB_idx;
    logic [NUM_FU-1:0][PR_IDX_W-1:0]  fu_T_idx;
    logic [NUM_FU-1:0]                fu_ready;
    logic                             rollback_en;
    logic [ROB_IDX_W-1:0]             ROB_rollback_idx;
    logic [ROB_IDX_W-1:0]             ROB_tail_idx;
    ROB_PACKET_COMPLETE_IN            rob_packet_complete_in;
    logic [PR_IDX_W-1:0]              cdb_T_idx;

    modport master (
        output fu_valid, fu_ROB_idx, fu_T_idx, rollback_en, ROB_rollback_idx, ROB_tail_idx,
        input  fu_ready, rob_packet_complete_in, cdb_T_idx
    );

    modport slave (
        input  fu_valid, fu_ROB_idx, fu_T_idx, rollback_en, ROB_rollback_idx, ROB_tail_idx,
        output fu_ready, rob_packet_complete_in, cdb_T_idx
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester after last_grant, searching cyclically.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [GW-1:0] grant_idx
);
    logic [GW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = GW'((32'(last_grant) + off) % N);
            if (grant == '0 && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/rob_complete_unit.sv
// Collects FU results in per-FU holding registers and completes one per cycle
// to the ROB/CDB, with rollback squash. COMPLETE_BYPASS_EN enables 0-cycle bypass.
module rob_complete_unit
    import sys_defs::*;
#(
    parameter int unsigned NUM_FU = 4
) (
    input logic               clock,
    input logic               reset,
    input logic               en,
    rob_complete_unit_if.slave bus
);
    localparam int unsigned GW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    COMPLETE_UNIT_ENTRY_t [NUM_FU-1:0] hold_q, hold_d;
    logic [GW-1:0]        last_grant_q, grant_idx;
    logic [NUM_FU-1:0]    hold_valid, req, grant_oh, grant_out_oh, ready, xfer;
    logic                 live, bypass, squash, grant_out;
    logic [ROB_IDX_W-1:0] win_rob;
    logic [PR_IDX_W-1:0]  win_t;
    ROB_PACKET_COMPLETE_IN pkt;

    assign live = reset & en;

    always_comb begin
        hold_valid = '0;
        for (int i = 0; i < NUM_FU; i++) hold_valid[i] = hold_q[i].valid;
    end

`ifdef COMPLETE_BYPASS_EN
    assign bypass = live & ~(|hold_valid);
`else
    assign bypass = 1'b0;
`endif

    assign req = bypass ? bus.fu_valid : (live ? hold_valid : '0);

    rr_arbiter #(.N(NUM_FU)) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant_oh),
        .grant_idx  (grant_idx)
    );

    // A younger winner during rollback is suppressed outright, never re-arbitrated.
    always_comb begin
        win_rob = hold_q[grant_idx].ROB_idx;
        win_t   = hold_q[grant_idx].T_idx;
        if (bypass) begin
            win_rob = bus.fu_ROB_idx[grant_idx];
            win_t   = bus.fu_T_idx[grant_idx];
        end
        squash       = bus.rollback_en & is_younger(win_rob, bus.ROB_rollback_idx, bus.ROB_tail_idx);
        grant_out    = (|grant_oh) & ~squash;
        grant_out_oh = grant_out ? grant_oh : '0;
    end

    always_comb begin
        pkt.complete_en      = grant_out;
        pkt.complete_ROB_idx = grant_out ? win_rob : '0;
    end

    assign bus.rob_packet_complete_in = pkt;
    assign bus.cdb_T_idx              = grant_out ? win_t : '0;
    assign ready                      = live ? (~hold_valid | grant_out_oh) : '0;
    assign bus.fu_ready               = ready;
    assign xfer                       = bus.fu_valid & ready;

    // Clear on completion or squash; a fresh non-younger transfer overrides the clear.
    always_comb begin
        hold_d = hold_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant_out_oh[i] ||
                (bus.rollback_en && hold_q[i].valid &&
                 is_younger(hold_q[i].ROB_idx, bus.ROB_rollback_idx, bus.ROB_tail_idx)))
                hold_d[i] = '0;
            if (xfer[i] && !(bypass && grant_oh[i]) &&
                !(bus.rollback_en &&
                  is_younger(bus.fu_ROB_idx[i], bus.ROB_rollback_idx, bus.ROB_tail_idx))) begin
                hold_d[i].valid   = 1'b1;
                hold_d[i].ROB_idx = bus.fu_ROB_idx[i];
                hold_d[i].T_idx   = bus.fu_T_idx[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q       <= '0;
            last_grant_q <= GW'(NUM_FU - 1);
        end else if (en) begin
            hold_q <= hold_d;
            if (grant_out) last_grant_q <= grant_idx;
        end
    end
endmodule

// File: tb/tb_rob_complete_unit.sv
// Directed-vector bench for rob_complete_unit (NUM_FU=4, NUM_ROB=32).
module tb_rob_complete_unit;
    import sys_defs::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rob_complete_unit_if #(.NUM_FU(4)) bus ();

    rob_complete_unit #(.NUM_FU(4)) dut (
        .clock (clk),
        .reset (rst_n),
        .en    (en),
        .bus   (bus.slave)
    );

    typedef struct {
        logic            rst;
        logic            en;
        logic [3:0]      fv;
        logic [3:0][4:0] rob;
        logic [3:0][5:0] t;
        logic            rb;
        logic [4:0]      b;
        logic [4:0]      tl;
        logic            ce;
        logic [4:0]      idx;
        logic [5:0]      ct;
        logic [3:0]      rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] robs(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic [23:0] trs(input int a0, input int a1, input int a2, input int a3);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    task automatic add(input logic rst, input logic e, input logic [3:0] fv,
                       input logic [19:0] rob, input logic [23:0] t,
                       input logic rb, input int b, input int tl,
                       input logic ce, input int idx, input int ct, input logic [3:0] rdy);
        vec_t v;
        v.rst = rst; v.en = e; v.fv = fv; v.rob = rob; v.t = t;
        v.rb = rb; v.b = 5'(b); v.tl = 5'(tl);
        v.ce = ce; v.idx = 5'(idx); v.ct = 6'(ct); v.rdy = rdy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n                = v.rst;
        en                   = v.en;
        bus.fu_valid         = v.fv;
        bus.fu_ROB_idx       = v.rob;
        bus.fu_T_idx         = v.t;
        bus.rollback_en      = v.rb;
        bus.ROB_rollback_idx = v.b;
        bus.ROB_tail_idx     = v.tl;
    endtask

    task automatic check_outputs(input int n, input logic ce, input int idx, input int ct, input logic [3:0] rdy);
        chk("complete_en", n, 32'(bus.rob_packet_complete_in.complete_en), 32'(ce));
        chk("complete_ROB_idx", n, 32'(bus.rob_packet_complete_in.complete_ROB_idx), 32'(idx));
        chk("cdb_T_idx", n, 32'(bus.cdb_T_idx), 32'(ct));
        chk("fu_ready", n, 32'(bus.fu_ready), 32'(rdy));
    endtask

    initial begin
        vec_t z;
        z.rst = 1'b0; z.en = 1'b1; z.fv = '0; z.rob = '0; z.t = '0;
        z.rb = 1'b0; z.b = '0; z.tl = '0;
        z.ce = 1'b0; z.idx = '0; z.ct = '0; z.rdy = '0;
        drive(z);

`ifdef COMPLETE_BYPASS_EN
        add(0,1,4'b0000, robs(0,0,0,0),   trs(0,0,0,0),    0,0,0, 0,0,0,   4'b0000);
        add(1,1,4'b1000, robs(0,0,0,11),  trs(0,0,0,3),    0,0,0, 1,11,3,  4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),   trs(0,0,0,0),    0,0,0, 0,0,0,   4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),   trs(0,0,0,0),    0,0,0, 0,0,0,   4'b1111);
`else
        // reset, then single result from FU2
        add(0,1,4'b1111, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b0000);
        add(1,1,4'b0100, robs(0,0,5,0),    trs(0,0,40,0),     0,0,0,  0,0,0,   4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  1,5,40,  4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b1111);
        // all four load; FU0/FU3 stay full afterwards
        add(0,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b0000);
        add(1,1,4'b1111, robs(20,21,22,23),trs(10,11,12,13),  0,0,0,  0,0,0,   4'b1111);
        add(1,1,4'b1001, robs(20,21,22,23),trs(10,11,12,13),  0,0,0,  1,20,10, 4'b0001);
        add(1,1,4'b1001, robs(20,21,22,23),trs(10,11,12,13),  0,0,0,  1,21,11, 4'b0010);
        add(1,1,4'b1001, robs(20,21,22,23),trs(10,11,12,13),  0,0,0,  1,22,12, 4'b0110);
        add(1,1,4'b1001, robs(20,21,22,23),trs(10,11,12,13),  0,0,0,  1,23,13, 4'b1110);
        add(1,1,4'b1001, robs(20,21,22,23),trs(10,11,12,13),  0,0,0,  1,20,10, 4'b0111);
        add(1,1,4'b1001, robs(20,21,22,23),trs(10,11,12,13),  0,0,0,  1,23,13, 4'b1110);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  1,20,10, 4'b0111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  1,23,13, 4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b1111);
        // FU1 reloaded while granted
        add(1,1,4'b0010, robs(0,4,0,0),    trs(0,30,0,0),     0,0,0,  0,0,0,   4'b1111);
        add(1,1,4'b0010, robs(0,7,0,0),    trs(0,31,0,0),     0,0,0,  1,4,30,  4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  1,7,31,  4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b1111);
        // wrap-around rollback b=28 t=4 after idx 3 has completed
        add(0,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b0000);
        add(1,1,4'b1111, robs(3,9,30,1),   trs(1,2,3,4),      0,0,0,  0,0,0,   4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  1,3,1,   4'b0001);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      1,28,4, 1,9,2,   4'b0011);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b1111);
        // younger grant suppressed, last_grant kept at FU1
        add(1,1,4'b0100, robs(0,0,15,0),   trs(0,0,5,0),      0,0,0,  0,0,0,   4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      1,10,20,0,0,0,   4'b1011);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b1111);
        add(1,1,4'b1100, robs(0,0,12,13),  trs(0,0,6,7),      0,0,0,  0,0,0,   4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  1,12,6,  4'b0111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  1,13,7,  4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b1111);
        // incoming younger result dropped during rollback b=8 t=20
        add(1,1,4'b0011, robs(6,12,0,0),   trs(8,9,0,0),      1,8,20, 0,0,0,   4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  1,6,8,   4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b1111);
        // enable low freezes state, rollback included
        add(1,1,4'b0010, robs(0,17,0,0),   trs(0,20,0,0),     0,0,0,  0,0,0,   4'b1111);
        add(1,0,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b0000);
        add(1,0,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      1,16,18,0,0,0,   4'b0000);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  1,17,20, 4'b1111);
        add(1,1,4'b0000, robs(0,0,0,0),    trs(0,0,0,0),      0,0,0,  0,0,0,   4'b1111);
`endif

        for (int n = 0; n < vecs.size(); n++) begin
            @(posedge clk);
            #1;
            drive(vecs[n]);
            #3;
            check_outputs(n, vecs[n].ce, 32'(vecs[n].idx), 32'(vecs[n].ct), vecs[n].rdy);
        end

`ifndef COMPLETE_BYPASS_EN
        // asynchronous reset between edges discards a pending result
        z.rst = 1'b1;
        @(posedge clk); #1;
        drive(z);
        bus.fu_valid = 4'b0001; bus.fu_ROB_idx = 20'(robs(9,0,0,0)); bus.fu_T_idx = 24'(trs(9,0,0,0));
        @(posedge clk); #1;
        bus.fu_valid = 4'b0000;
        #1;
        check_outputs(100, 1'b1, 9, 9, 4'b1111);
        rst_n = 1'b0;
        #1;
        check_outputs(101, 1'b0, 0, 0, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check_outputs(102, 1'b0, 0, 0, 4'b1111);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
